sum_arbiter: RTL and testbench

- Shares one registered adder (`sum`: inputs a, b; output c; fixed pipeline latency) between two requesters.
- Each requester issues operand pairs through a valid/ready handshake and gets its own one-cycle result pulse.
- Arbitration is round-robin. The controller tracks which requester owns each in-flight operation.
- Sits between the stimulus/producer logic and the `sum` instance, and drives the adder's a/b ports directly.

---
 rtl/sum_arbiter.sv | 134 +++++++++++++
 tb/tb_sum_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_arbiter.sv
// ---------------------------------------------------------------------------
// sum_arbiter
//   Shares one registered adder between two requesters. Grants are issued
//   round-robin through a valid/ready handshake. The winner's operands are
//   registered straight onto the adder ports. A tag pipeline follows each
//   operation through the adder, so the result can be returned as a
//   one-cycle pulse to the requester that issued it.
//
// Parameters
//   WIDTH   operand/result width (must match the adder)
//   LAT     adder latency in clocks, 1..4
//
// Ports
//   clk, aresetn            clock, asynchronous active-low reset
//   en                      grant enable (0 = no new grants, in-flight drain)
//   req0_valid/ready/a/b    requester 0 handshake and operands
//   req1_valid/ready/a/b    requester 1 handshake and operands
//   sum_a, sum_b            registered operands driven to the adder
//   sum_c                   adder result
//   rsp0_valid, rsp1_valid  one-cycle result pulses, one per requester
//   rsp_c                   result data, held between pulses
//   busy                    an operation is in flight or being returned
// ---------------------------------------------------------------------------
module sum_arbiter #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] sum_a,
  output logic [WIDTH-1:0] sum_b,
  input  logic [WIDTH-1:0] sum_c,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_c,
  output logic             busy
);

  // One entry per pipeline stage: is there an operation, and whose is it.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  logic grant0;
  logic grant1;
  logic transfer;
  logic ptr;               // requester that wins when both are valid
  tag_t tags [LAT+1];      // stage LAT lines up with sum_c being valid
  logic busy_c;

  // Grant. Gated by aresetn so ready stays low while the block is held in
  // reset, even if a requester is already presenting data.
  // NOTE: every signal written in this always_comb gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en && aresetn) begin
      if (req0_valid && (!req1_valid || ptr == 1'b0)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign transfer   = grant0 | grant1;

  // Pointer, operand registers and the tag pipeline.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, which is what makes the tag pipeline shift
  // rather than fall straight through in one clock.
  // NOTE: the tag pipeline is reset stage by stage; leaving it unreset
  // would let stale tags fire spurious responses after reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ptr   <= 1'b0;
      sum_a <= '0;
      sum_b <= '0;
      for (int k = 0; k <= LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      if (transfer) begin
        // Loser-first: the requester that just won yields priority.
        ptr   <= grant0;
        sum_a <= grant1 ? req1_a : req0_a;
        sum_b <= grant1 ? req1_b : req0_b;
      end
      tags[0] <= '{valid: transfer, id: grant1};
      for (int k = 1; k <= LAT; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

  // Response: the final tag stage is valid exactly when sum_c carries the
  // matching result, so capture it and steer the pulse by the tag id.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_c      <= '0;
    end else begin
      rsp0_valid <= tags[LAT].valid && !tags[LAT].id;
      rsp1_valid <= tags[LAT].valid &&  tags[LAT].id;
      if (tags[LAT].valid) begin
        rsp_c <= sum_c;
      end
    end
  end

  always_comb begin
    busy_c = rsp0_valid | rsp1_valid;
    for (int k = 0; k <= LAT; k++) begin
      busy_c = busy_c | tags[k].valid;
    end
  end

  assign busy = busy_c;

endmodule

// File: tb/tb_sum_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sum_arbiter
//   Two instances: LAT=1 (instance 0) and LAT=3 (instance 1), each with a
//   behavioural registered adder. Every grant the bench expects pushes the
//   expected result, owner and arrival cycle onto a scoreboard queue; a
//   negedge monitor pops and compares each response pulse.
// ---------------------------------------------------------------------------
module tb_sum_arbiter;

  localparam int W    = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  typedef struct {
    int           inst;
    logic         id;
    logic [W-1:0] c;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [1:0]        en, v0, v1, r0, r1, rv0, rv1, busy;
  logic [1:0][W-1:0] a0, b0, a1, b1, sa, sb_op, sc, rc;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [1:0] ptr_m;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LG = (g == 0) ? LAT0 : LAT1;
    logic [W-1:0] pipe [LG];

    // Registered adder with LG clocks of latency.
    always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        for (int k = 0; k < LG; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= sa[g] + sb_op[g];
        for (int k = 1; k < LG; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign sc[g] = pipe[LG-1];

    sum_arbiter #(.WIDTH(W), .LAT(LG)) u_dut (
      .clk        (clk),
      .aresetn    (aresetn),
      .en         (en[g]),
      .req0_valid (v0[g]),
      .req0_ready (r0[g]),
      .req0_a     (a0[g]),
      .req0_b     (b0[g]),
      .req1_valid (v1[g]),
      .req1_ready (r1[g]),
      .req1_a     (a1[g]),
      .req1_b     (b1[g]),
      .sum_a      (sa[g]),
      .sum_b      (sb_op[g]),
      .sum_c      (sc[g]),
      .rsp0_valid (rv0[g]),
      .rsp1_valid (rv1[g]),
      .rsp_c      (rc[g]),
      .busy       (busy[g])
    );
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (aresetn === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        if (rv0[i] | rv1[i]) begin
          check("rsp_onehot", 32'(rv0[i] & rv1[i]), 0);
          if (sb.size() == 0) begin
            check("unexpected_rsp", 1, 0);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_inst", i, mon_e.inst);
            check("rsp_id", 32'(rv1[i]), 32'(mon_e.id));
            check("rsp_c", 32'(rc[i]), 32'(mon_e.c));
            check("rsp_cycle", cyc, mon_e.due);
          end
        end
      end
    end
  end

  // Drive one cycle on instance i (called just after a rising edge), check
  // the grant against the round-robin model, and log any transfer.
  task automatic drive(int i, logic e, logic q0, logic [W-1:0] x0, logic [W-1:0] y0,
                       logic q1, logic [W-1:0] x1, logic [W-1:0] y1);
    logic g0, g1;
    logic [W-1:0] s;
    en[i] = e;
    v0[i] = q0; a0[i] = x0; b0[i] = y0;
    v1[i] = q1; a1[i] = x1; b1[i] = y1;
    @(negedge clk);
    g0 = e && q0 && (!q1 || ptr_m[i] == 1'b0);
    g1 = e && q1 && !g0;
    check("ready0", 32'(r0[i]), 32'(g0));
    check("ready1", 32'(r1[i]), 32'(g1));
    if (g0 || g1) begin
      s = g1 ? (x1 + y1) : (x0 + y0);
      sb.push_back('{inst: i, id: g1, c: s, due: cyc + ((i == 0) ? LAT0 : LAT1) + 2});
      ptr_m[i] = ~g1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int i, int n);
    for (int k = 0; k < n; k++) drive(i, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    en = '0; v0 = '0; v1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    ptr_m = '0;
    aresetn = 1'b1;
    #1 aresetn = 1'b0;

    // Reset state, with a requester already presenting data.
    en[0] = 1'b1; v0[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(r0[0]), 0);
    check("rst_sum_a", 32'(sa[0]), 0);
    check("rst_sum_b", 32'(sb_op[0]), 0);
    check("rst_rsp_c", 32'(rc[0]), 0);
    check("rst_rsp_valid", 32'({rv0[0], rv1[0]}), 0);
    check("rst_busy", 32'(busy), 0);
    en[0] = 1'b0; v0[0] = 1'b0;
    @(posedge clk);
    #1 aresetn = 1'b1;

    // Single req0 transfer.
    drive(0, 1'b1, 1'b1, 8'h10, 8'h05, 1'b0, '0, '0);
    idle(0, 4);

    // Overflow on req1 (carry dropped); also leaves the pointer on req0.
    drive(0, 1'b1, 1'b0, '0, '0, 1'b1, 8'hFF, 8'h02);
    idle(0, 3);

    // Both continuously valid: grants alternate, responses back-to-back.
    for (int k = 0; k < 4; k++) drive(0, 1'b1, 1'b1, 8'd1, 8'd2, 1'b1, 8'd10, 8'd20);

    // en low with both valid while the last ops drain, then resume.
    for (int k = 0; k < 3; k++) drive(0, 1'b0, 1'b1, 8'd7, 8'd8, 1'b1, 8'd40, 8'd2);
    for (int k = 0; k < 2; k++) drive(0, 1'b1, 1'b1, 8'd7, 8'd8, 1'b1, 8'd40, 8'd2);
    idle(0, 4);

    // Requester waves valid but en is off: ignored, nothing changes.
    drive(0, 1'b0, 1'b0, '0, '0, 1'b1, 8'd9, 8'd9);
    idle(0, 3);

    // Reset with two operations in flight.
    drive(0, 1'b1, 1'b1, 8'd3, 8'd4, 1'b0, '0, '0);
    drive(0, 1'b1, 1'b0, '0, '0, 1'b1, 8'd5, 8'd6);
    aresetn = 1'b0;
    sb.delete();
    ptr_m = '0;
    en = '0; v0 = '0; v1 = '0;
    @(negedge clk);
    check("midrst_busy", 32'(busy[0]), 0);
    check("midrst_sum_a", 32'(sa[0]), 0);
    check("midrst_sum_b", 32'(sb_op[0]), 0);
    @(posedge clk);
    #1 aresetn = 1'b1;
    idle(0, 5);
    @(negedge clk);
    check("postrst_busy", 32'(busy[0]), 0);
    check("postrst_rsp", 32'({rv0[0], rv1[0]}), 0);
    @(posedge clk);
    #1;
    // Pointer back at 0: req0 wins the first contested grant.
    drive(0, 1'b1, 1'b1, 8'd11, 8'd22, 1'b1, 8'd33, 8'd44);
    idle(0, 4);

    // LAT=3 instance: 4-clock latency, busy high for the whole flight.
    drive(1, 1'b1, 1'b1, 8'd100, 8'd27, 1'b0, '0, '0);
    for (int k = 0; k < 7; k++) begin
      en[1] = 1'b1; v0[1] = 1'b0; v1[1] = 1'b0;
      @(negedge clk);
      check("lat3_busy", 32'(busy[1]), 32'(k < 5));
      @(posedge clk);
      #1;
    end

    idle(0, 4);
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
